video_gen_mc: RTL and testbench
===============================

Name: video_gen_mc

Overview:
- Multi-channel, runtime-configurable video test-pattern source for stream-based pipelines.
- Emits one pixel per accepted beat: CHANNELS components of BITS each, with sop/eol/eop framing.
- Adds optional line/frame blanking gaps, a frame counter and an animated pattern.
- Honours a full valid/ready handshake: the output beat is held stable while stalled.

Parameters:
BITS, 8, bits per colour component
CHANNELS, 3, components per pixel; channel c occupies data[c*BITS +: BITS]
ROWS, 240, active lines per frame (>=2)
COLS, 320, active pixels per line (>=8)
CHECKER_LOG2, 5, checker square size = 2**CHECKER_LOG2 pixels
HGAP, 0, idle cycles (valid low) after each non-final line
VGAP, 0, idle cycles (valid low) after each frame

Ports:
clk  in  1  clock; all logic on rising edge
srst  in  1  synchronous active-high reset
enable  in  1  run request, sampled only at frame boundaries
pattern_sel  in  3  pattern select, latched at frame start
ready  in  1  downstream can accept a beat this cycle
data  out  BITS*CHANNELS  pixel components
valid  out  1  beat present
sop  out  1  first pixel of frame (row 0, col 0)
eol  out  1  last pixel of each line
eop  out  1  last pixel of frame
frame_count  out  16  number of frames whose eop beat was accepted, wraps at 2**16

Behaviour:
- Transfer: valid && ready. While valid && !ready, data, sop, eol, eop and valid hold unchanged.
- Output register loads the next beat when !valid || ready.
- Reset (srst=1, any cycle, including mid-frame or mid-gap): valid, sop, eol, eop, data, frame_count, row/col counters and gap counter all 0; state IDLE; latched pattern 0. srst has priority over all other inputs.
- States:
  - IDLE: if enable=1, latch pattern_sel, load pixel (0,0) with sop=1, go ACTIVE. First valid appears the cycle after enable is seen in IDLE.
  - ACTIVE: on each transfer, advance col. After a transfer with col=COLS-1:
    - row<ROWS-1: if HGAP=0, load the next line's pixel 0 in the same cycle (no bubble); otherwise drop valid and go HBLANK.
    - row=ROWS-1 (eop beat): frame_count+1. If VGAP=0, behave as IDLE in that same cycle (enable=1 gives back-to-back frames); otherwise go VBLANK.
  - HBLANK: valid=0 for exactly HGAP cycles, counted regardless of ready, then load the next line's pixel 0.
  - VBLANK: valid=0 for exactly VGAP cycles, then IDLE evaluation.
- enable deasserted mid-frame: the frame completes; the block stops at the next boundary.
- pattern_sel changes mid-frame are ignored until the next sop.
- Flags: sop=(r==0&&c==0); eol=(c==COLS-1); eop=(r==ROWS-1&&c==COLS-1). sop and eop are never both set; eol is set with eop.
- Patterns: r,c are the pixel coordinates; f is frame_count at frame start; all results truncated to BITS LSBs. Unless noted, every channel carries the same value.
  - 0: c
  - 1: r
  - 2: r+c
  - 3: all-ones if bit CHECKER_LOG2 of c XOR bit CHECKER_LOG2 of r, else 0
  - 4: colour bars; bar=(c*8)/COLS (0..7); channel k is all-ones if bit (k mod 3) of (7-bar) is set, else 0
  - 5: r+c+f (moving diagonal)
  - 6: all-ones (flat field)
  - 7: channel k = c + k*(2**BITS/CHANNELS) (per-channel offset ramp)
- Counters wrap cleanly; frame_count 65535 -> 0 on the next eop transfer.

Test Plan:
- Use ROWS=4, COLS=8, BITS=8, CHANNELS=3 unless stated.
- Free run, ready=1, HGAP=VGAP=0, sel=0: 32 consecutive valid beats; channel 0 = 0..7 repeating; sop on beat 0; eol on beats 7,15,23,31; eop on beat 31 only; frame_count=1 after beat 31; frame 2 starts with no bubble.
- Random ready stalls, sel=2: every beat is held stable while !ready; accepted sequence is exactly r+c in raster order; no beat lost or duplicated.
- HGAP=2, VGAP=3: exactly 2 valid-low cycles after beats 7,15,23 and 3 after beat 31; no sop/eol/eop during gaps.
- sel=4, COLS=8: channels (2,1,0) per column = (1,1,1),(1,1,0),(1,0,1),(1,0,0),(0,1,1),(0,1,0),(0,0,1),(0,0,0), where 1 = 0xFF; sel changed to 6 mid-frame takes effect only at the next sop.
- enable dropped at pixel (1,3): the frame completes through eop, then valid stays 0; re-enable gives sop one cycle later. sel=5 frame 2 pixel (0,0) = 1.
- srst pulsed at pixel (2,5) during a stall: all outputs 0 the next cycle; after release with enable=1, the next beat is (0,0) with sop=1 and frame_count=0.

Source files
------------

// File: rtl/video_gen_mc.sv
// Multi-channel stream test-pattern source: raster-ordered pixels with sop/eol/eop
// framing, optional line/frame blanking, a frame counter and a valid/ready handshake.
module video_gen_mc #(
  parameter int BITS         = 8,
  parameter int CHANNELS     = 3,
  parameter int ROWS         = 240,
  parameter int COLS         = 320,
  parameter int CHECKER_LOG2 = 5,
  parameter int HGAP         = 0,
  parameter int VGAP         = 0
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     enable,
  input  logic [2:0]               pattern_sel,
  input  logic                     ready,
  output logic [BITS*CHANNELS-1:0] data,
  output logic                     valid,
  output logic                     sop,
  output logic                     eol,
  output logic                     eop,
  output logic [15:0]              frame_count
);

  localparam int DW     = BITS * CHANNELS;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MAXGAP = (HGAP > VGAP) ? HGAP : VGAP;
  localparam int GW     = (MAXGAP > 1) ? $clog2(MAXGAP) : 1;
  localparam int CH_OFS = (2 ** BITS) / CHANNELS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [2:0]        pat_q, pat_d;
  logic [15:0]       fbase_q, fbase_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [DW-1:0]     data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eol_q, eol_d;
  logic              eop_q, eop_d;

  // Pattern value of pixel (r, c) for frame number f under pattern sel.
  function automatic logic [DW-1:0] pixel(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                          input logic [2:0] sel, input logic [15:0] f);
    logic [DW-1:0]   px;
    logic [BITS-1:0] v;
    logic [2:0]      bar_inv;
    px      = '0;
    bar_inv = 3'(32'd7 - (32'(c) * 32'd8) / 32'(COLS));
    for (int k = 0; k < CHANNELS; k++) begin
      case (sel)
        3'd0:    v = BITS'(32'(c));
        3'd1:    v = BITS'(32'(r));
        3'd2:    v = BITS'(32'(r) + 32'(c));
        3'd3:    v = ((((32'(c) >> CHECKER_LOG2) ^ (32'(r) >> CHECKER_LOG2)) & 32'd1) != 32'd0)
                     ? '1 : '0;
        3'd4:    v = bar_inv[k % 3] ? '1 : '0;
        3'd5:    v = BITS'(32'(r) + 32'(c) + 32'(f));
        3'd6:    v = '1;
        default: v = BITS'(32'(c) + 32'(k) * 32'(CH_OFS));
      endcase
      px[k*BITS +: BITS] = v;
    end
    return px;
  endfunction

  logic          xfer;
  logic          last_col;
  logic          last_row;
  logic          try_start;
  logic          load;
  logic [RW-1:0] ld_row;
  logic [CW-1:0] ld_col;

  // NOTE: combinational next-state logic uses blocking '=' with a default for every
  // variable up front, so no path through the case can leave a latch behind.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    gap_d         = gap_q;
    pat_d         = pat_q;
    fbase_d       = fbase_q;
    frame_count_d = frame_count_q;
    data_d        = data_q;
    valid_d       = valid_q;
    sop_d         = sop_q;
    eol_d         = eol_q;
    eop_d         = eop_q;
    try_start     = 1'b0;
    load          = 1'b0;
    ld_row        = row_q;
    ld_col        = '0;

    xfer     = valid_q && ready;
    last_col = (col_q == CW'(COLS - 1));
    last_row = (row_q == RW'(ROWS - 1));

    case (state_q)
      S_IDLE: try_start = 1'b1;

      S_ACTIVE: begin
        if (xfer) begin
          if (!last_col) begin
            load   = 1'b1;
            ld_col = col_q + CW'(1);
          end else if (!last_row) begin
            if (HGAP == 0) begin
              load   = 1'b1;
              ld_row = row_q + RW'(1);
            end else begin
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eol_d   = 1'b0;
              eop_d   = 1'b0;
              gap_d   = '0;
              state_d = S_HBLANK;
            end
          end else begin
            frame_count_d = frame_count_q + 16'd1;
            valid_d       = 1'b0;
            sop_d         = 1'b0;
            eol_d         = 1'b0;
            eop_d         = 1'b0;
            gap_d         = '0;
            if (VGAP == 0) try_start = 1'b1;
            else           state_d   = S_VBLANK;
          end
        end
      end

      S_HBLANK: begin
        if (gap_q == GW'(HGAP - 1)) begin
          load    = 1'b1;
          ld_row  = row_q + RW'(1);
          state_d = S_ACTIVE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_VBLANK: begin
        if (gap_q == GW'(VGAP - 1)) try_start = 1'b1;
        else                        gap_d     = gap_q + GW'(1);
      end

      default: state_d = S_IDLE;
    endcase

    // Frame boundary: enable and pattern_sel only matter here.
    if (try_start) begin
      state_d = S_IDLE;
      if (enable) begin
        load    = 1'b1;
        ld_row  = '0;
        ld_col  = '0;
        pat_d   = pattern_sel;
        fbase_d = frame_count_d;
        state_d = S_ACTIVE;
      end
    end

    if (load) begin
      row_d   = ld_row;
      col_d   = ld_col;
      data_d  = pixel(ld_row, ld_col, pat_d, fbase_d);
      valid_d = 1'b1;
      sop_d   = (ld_row == '0) && (ld_col == '0);
      eol_d   = (ld_col == CW'(COLS - 1));
      eop_d   = (ld_row == RW'(ROWS - 1)) && (ld_col == CW'(COLS - 1));
    end
  end

  // NOTE: every register here is a small control/datapath flop, so all of them take
  // the synchronous reset; sequential state is assigned only with '<='.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      gap_q         <= '0;
      pat_q         <= '0;
      fbase_q       <= '0;
      frame_count_q <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eol_q         <= 1'b0;
      eop_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      gap_q         <= gap_d;
      pat_q         <= pat_d;
      fbase_q       <= fbase_d;
      frame_count_q <= frame_count_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      sop_q         <= sop_d;
      eol_q         <= eol_d;
      eop_q         <= eop_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign sop         = sop_q;
  assign eol         = eol_q;
  assign eop         = eop_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_gen_mc.sv
// Self-checking bench for video_gen_mc: two instances (no gaps / HGAP=2,VGAP=3)
// driven from shared inputs, checked against a raster-order reference model.
module tb_video_gen_mc;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int CK   = 1;
  localparam int FRM  = ROWS * COLS;

  logic        clk = 1'b0;
  logic        srst;
  logic        enable;
  logic [2:0]  pattern_sel;
  logic        ready;

  logic [23:0] data_o  [2];
  logic        valid_o [2];
  logic        sop_o   [2];
  logic        eol_o   [2];
  logic        eop_o   [2];
  logic [15:0] fc_o    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_gen_mc #(.BITS(8), .CHANNELS(3), .ROWS(ROWS), .COLS(COLS), .CHECKER_LOG2(CK),
                 .HGAP(0), .VGAP(0)) dut0 (
    .clk(clk), .srst(srst), .enable(enable), .pattern_sel(pattern_sel), .ready(ready),
    .data(data_o[0]), .valid(valid_o[0]), .sop(sop_o[0]), .eol(eol_o[0]), .eop(eop_o[0]),
    .frame_count(fc_o[0])
  );

  video_gen_mc #(.BITS(8), .CHANNELS(3), .ROWS(ROWS), .COLS(COLS), .CHECKER_LOG2(CK),
                 .HGAP(2), .VGAP(3)) dut1 (
    .clk(clk), .srst(srst), .enable(enable), .pattern_sel(pattern_sel), .ready(ready),
    .data(data_o[1]), .valid(valid_o[1]), .sop(sop_o[1]), .eol(eol_o[1]), .eop(eop_o[1]),
    .frame_count(fc_o[1])
  );

  typedef struct {
    logic       rdy;
    logic [7:0] ch0;
    logic       sop;
    logic       eol;
    logic       eop;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst        = 1'b1;
    enable      = 1'b0;
    ready       = 1'b1;
    pattern_sel = 3'd0;
    tick();
    tick();
    srst = 1'b0;
  endtask

  // Reference pixel value straight from the pattern definitions.
  function automatic logic [23:0] exp_pix(input int r, input int c, input int sel, input int f);
    logic [23:0] px;
    int v;
    int bar;
    px = '0;
    for (int k = 0; k < 3; k++) begin
      case (sel)
        0: v = c;
        1: v = r;
        2: v = r + c;
        3: v = ((((c >> CK) ^ (r >> CK)) & 1) != 0) ? 255 : 0;
        4: begin
          bar = (c * 8) / COLS;
          v   = (((7 - bar) >> (k % 3)) & 1) != 0 ? 255 : 0;
        end
        5: v = r + c + f;
        6: v = 255;
        default: v = c + k * (256 / 3);
      endcase
      px[k*8 +: 8] = v[7:0];
    end
    return px;
  endfunction

  // Accept nbeats beats from instance d, checking order, hold-while-stalled and gap lengths.
  task automatic run_stream(input int d, input int hg, input int vg, input int sel,
                            input int nbeats, input bit rand_rdy);
    int n = 0;
    int cyc = 0;
    int gap_cnt = 0;
    int exp_gap = 0;
    bit pend = 0;
    bit stalled = 0;
    bit rdy;
    int r, c, fr;
    logic [27:0] cur, snap;
    snap = '0;
    while (n < nbeats && cyc < 4000) begin
      cur = {valid_o[d], data_o[d], sop_o[d], eol_o[d], eop_o[d]};
      if (stalled) check("hold_while_stalled", cur, snap);
      if (!valid_o[d]) begin
        gap_cnt++;
        check("flags_in_gap", {sop_o[d], eol_o[d], eop_o[d]}, 3'b000);
      end else if (pend) begin
        check("gap_length", gap_cnt, exp_gap);
        pend = 0;
      end
      rdy   = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      ready = rdy;
      if (valid_o[d] && rdy) begin
        r  = (n / COLS) % ROWS;
        c  = n % COLS;
        fr = n / FRM;
        check("beat", {data_o[d], sop_o[d], eol_o[d], eop_o[d], fc_o[d]},
              {exp_pix(r, c, sel, fr), (r == 0 && c == 0), (c == COLS - 1),
               (r == ROWS - 1 && c == COLS - 1), 16'(fr)});
        if (c == COLS - 1) begin
          pend    = 1;
          gap_cnt = 0;
          exp_gap = (r == ROWS - 1) ? vg : hg;
        end
        n++;
      end
      stalled = valid_o[d] && !rdy;
      snap    = cur;
      tick();
      cyc++;
    end
    if (n < nbeats) check("stream_timeout", n, nbeats);
    ready = 1'b1;
  endtask

  initial begin
    vec_t       tbl [FRM];
    logic [2:0] bars [8];
    logic [23:0] bexp;
    int sels [4];

    srst = 1'b1; enable = 1'b0; ready = 1'b1; pattern_sel = 3'd0;

    // Reset state, with enable high to confirm srst priority.
    enable = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++)
      check("reset_outputs", {valid_o[d], data_o[d], sop_o[d], eol_o[d], eop_o[d], fc_o[d]}, '0);

    // Free run, sel=0: table of expected beats for one frame.
    for (int i = 0; i < FRM; i++) begin
      tbl[i].rdy = 1'b1;
      tbl[i].ch0 = 8'(i % COLS);
      tbl[i].sop = (i == 0);
      tbl[i].eol = (i % COLS == COLS - 1);
      tbl[i].eop = (i == FRM - 1);
    end
    do_reset();
    enable = 1'b1;
    pattern_sel = 3'd0;
    tick();
    for (int i = 0; i < FRM; i++) begin
      ready = tbl[i].rdy;
      check("free_run_beat", {valid_o[0], data_o[0], sop_o[0], eol_o[0], eop_o[0]},
            {1'b1, {3{tbl[i].ch0}}, tbl[i].sop, tbl[i].eol, tbl[i].eop});
      tick();
    end
    check("free_run_fc_after_eop", fc_o[0], 16'd1);
    check("free_run_frame2_no_bubble", {valid_o[0], sop_o[0], data_o[0]}, {1'b1, 1'b1, 24'h0});

    // Random stalls on the gapless instance, sel=2.
    do_reset();
    enable = 1'b1; pattern_sel = 3'd2;
    run_stream(0, 0, 0, 2, 2 * FRM, 1'b1);

    // Blanking gaps, ready held high, then random stalls with the moving diagonal.
    do_reset();
    enable = 1'b1; pattern_sel = 3'd0;
    run_stream(1, 2, 3, 0, 2 * FRM, 1'b0);
    do_reset();
    enable = 1'b1; pattern_sel = 3'd5;
    run_stream(1, 2, 3, 5, 3 * FRM, 1'b1);

    // Remaining patterns over two frames each.
    sels = '{1, 3, 6, 7};
    for (int s = 0; s < 4; s++) begin
      do_reset();
      enable = 1'b1; pattern_sel = 3'(sels[s]);
      run_stream(0, 0, 0, sels[s], 2 * FRM, 1'b1);
    end

    // Colour bars; a mid-frame switch to flat field lands only on the next sop.
    bars = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};
    do_reset();
    enable = 1'b1; pattern_sel = 3'd4;
    tick();
    for (int i = 0; i < FRM; i++) begin
      if (i == 3) pattern_sel = 3'd6;
      for (int k = 0; k < 3; k++) bexp[k*8 +: 8] = bars[i % COLS][k] ? 8'hFF : 8'h00;
      check("colour_bars", {valid_o[0], data_o[0]}, {1'b1, bexp});
      tick();
    end
    check("sel_change_at_sop", {valid_o[0], sop_o[0], data_o[0]}, {1'b1, 1'b1, 24'hFFFFFF});

    // enable dropped at pixel (1,3): frame completes, then idle until re-enabled.
    do_reset();
    enable = 1'b1; pattern_sel = 3'd5;
    tick();
    for (int i = 0; i < FRM; i++) begin
      if (i == COLS + 3) enable = 1'b0;
      check("drain_beat", {valid_o[0], data_o[0], eop_o[0]},
            {1'b1, exp_pix(i / COLS, i % COLS, 5, 0), (i == FRM - 1)});
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("stopped_valid_low", valid_o[0], 1'b0);
      tick();
    end
    enable = 1'b1;
    tick();
    check("restart_first_beat", {valid_o[0], sop_o[0], data_o[0], fc_o[0]},
          {1'b1, 1'b1, 24'h010101, 16'd1});

    // srst while stalled at pixel (2,5) of the second frame.
    do_reset();
    enable = 1'b1; pattern_sel = 3'd0;
    tick();
    for (int i = 0; i < FRM + 2 * COLS + 5; i++) tick();
    check("pre_reset_pixel", {valid_o[0], data_o[0], fc_o[0]}, {1'b1, 24'h050505, 16'd1});
    ready = 1'b0;
    tick();
    tick();
    check("stall_hold_before_reset", {valid_o[0], data_o[0]}, {1'b1, 24'h050505});
    srst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++)
      check("midframe_reset_outputs",
            {valid_o[d], data_o[d], sop_o[d], eol_o[d], eop_o[d], fc_o[d]}, '0);
    srst  = 1'b0;
    ready = 1'b1;
    tick();
    check("post_reset_first_beat", {valid_o[0], sop_o[0], data_o[0], fc_o[0]},
          {1'b1, 1'b1, 24'h0, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
